frame_sequencer: RTL and testbench

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/frame_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_frame_sequencer.sv | 525 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frame_sequencer                                                            |
// | Cuts a sample stream into overlapping WIN_LENGTH frames advanced by        |
// | HOP_LENGTH, steering the frame buffer's write, read, jump and init ports.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module frame_sequencer #(
    parameter int WIN_LENGTH = 480,
    parameter int HOP_LENGTH = 160
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] n_frames,
    input  logic        stop,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        buf_full,
    input  logic        buf_empty,
    output logic        buf_wr_en,
    output logic        buf_rd_en,
    output logic        buf_rd_jump,
    output logic        buf_frm_init,
    output logic        out_valid,
    output logic        out_first,
    output logic        out_last,
    output logic [15:0] frame_idx,
    output logic        busy,
    output logic        done
);

    localparam int ADDR_WIDTH = $clog2(2 ** $clog2(WIN_LENGTH));
    localparam int CNT_WIDTH  = $clog2(WIN_LENGTH);
    localparam int AV_WIDTH   = ADDR_WIDTH + 1;

    localparam logic [AV_WIDTH-1:0]  C_WIN     = AV_WIDTH'(WIN_LENGTH);
    localparam logic [AV_WIDTH-1:0]  C_HOP     = AV_WIDTH'(HOP_LENGTH);
    localparam logic [AV_WIDTH-1:0]  C_AV_MAX  = AV_WIDTH'(2 ** ADDR_WIDTH);
    localparam logic [CNT_WIDTH-1:0] C_LAST_RD = CNT_WIDTH'(WIN_LENGTH - 1);
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_INIT = 2'd2;
    localparam logic [1:0] S_READ = 2'd3;

    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic [AV_WIDTH-1:0]  avail_q;
    logic [AV_WIDTH-1:0]  avail_d;
    logic [AV_WIDTH:0]    w_avail_sum;
    logic [CNT_WIDTH-1:0] rd_cnt_q;
    logic [15:0]          frame_idx_q;
    logic [15:0]          nfr_q;
    logic                 stop_q;
    logic                 out_valid_q;
    logic                 out_first_q;
    logic                 out_last_q;
    logic                 done_q;

    logic                 w_last_rd;
    logic                 w_more;
    logic                 w_stop_pend;
    logic                 w_end;

    assign w_more      = (nfr_q == 16'd0) ||
                         (({1'b0, frame_idx_q} + 17'd1) < {1'b0, nfr_q});
    assign w_stop_pend = stop_q | stop;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        w_end   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (w_stop_pend) begin
                    state_d = S_IDLE;
                    w_end   = 1'b1;
                end else if (avail_q >= C_WIN) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                state_d = S_READ;
            end
            S_READ: begin
                if (w_last_rd) begin
                    if (w_more && !w_stop_pend) begin
                        state_d = S_FILL;
                    end else begin
                        state_d = S_IDLE;
                        w_end   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        busy         = (state_q != S_IDLE);
        in_ready     = busy & ~buf_full;
        buf_wr_en    = in_valid & in_ready;
        buf_frm_init = (state_q == S_INIT);
        buf_rd_en    = (state_q == S_READ) & ~buf_empty;
        w_last_rd    = buf_rd_en & (rd_cnt_q == C_LAST_RD);
        buf_rd_jump  = w_last_rd;
    end

    // Occupancy of the unread window; the jump releases one hop of samples.
    always_comb begin
        w_avail_sum = {1'b0, avail_q} + {{AV_WIDTH{1'b0}}, buf_wr_en};
        if (buf_rd_jump) begin
            w_avail_sum = w_avail_sum - {1'b0, C_HOP};
        end
        if (w_avail_sum > {1'b0, C_AV_MAX}) begin
            avail_d = C_AV_MAX;
        end else begin
            avail_d = w_avail_sum[AV_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avail_q     <= '0;
            rd_cnt_q    <= '0;
            frame_idx_q <= '0;
            nfr_q       <= '0;
            stop_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            avail_q     <= avail_d;
            out_valid_q <= buf_rd_en;
            out_first_q <= buf_rd_en & (rd_cnt_q == '0);
            out_last_q  <= w_last_rd;
            done_q      <= w_end;

            if (w_last_rd) begin
                rd_cnt_q <= '0;
            end else if (buf_rd_en) begin
                rd_cnt_q <= rd_cnt_q + C_CNT_ONE;
            end

            if (state_q == S_IDLE) begin
                if (start) begin
                    nfr_q       <= n_frames;
                    frame_idx_q <= '0;
                end
            end else if (w_last_rd) begin
                frame_idx_q <= frame_idx_q + 16'd1;
            end

            // A stop request is held until the sequence actually ends.
            if (state_q == S_IDLE || w_end) begin
                stop_q <= 1'b0;
            end else if (stop) begin
                stop_q <= 1'b1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign frame_idx = frame_idx_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_frame_sequencer                                                         |
// | Self-checking bench: frame-buffer model, frame reference model, scenarios. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_frame_sequencer;

    localparam int WIN       = 480;
    localparam int HOP       = 160;
    localparam int BUF_DEPTH = 512;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] n_frames;
    logic        stop;
    logic        in_valid;
    logic        in_ready;
    logic        buf_full;
    logic        buf_empty;
    logic        buf_wr_en;
    logic        buf_rd_en;
    logic        buf_rd_jump;
    logic        buf_frm_init;
    logic        out_valid;
    logic        out_first;
    logic        out_last;
    logic [15:0] frame_idx;
    logic        busy;
    logic        done;
    logic        force_empty;

    int tests_run;
    int tests_failed;

    frame_sequencer #(
        .WIN_LENGTH (WIN),
        .HOP_LENGTH (HOP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .n_frames     (n_frames),
        .stop         (stop),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .buf_full     (buf_full),
        .buf_empty    (buf_empty),
        .buf_wr_en    (buf_wr_en),
        .buf_rd_en    (buf_rd_en),
        .buf_rd_jump  (buf_rd_jump),
        .buf_frm_init (buf_frm_init),
        .out_valid    (out_valid),
        .out_first    (out_first),
        .out_last     (out_last),
        .frame_idx    (frame_idx),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame buffer: absolute write count, frame start and read pointer.
    int b_wr;
    int b_frm;
    int b_rd;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_wr  <= 0;
            b_frm <= 0;
            b_rd  <= 0;
        end else begin
            if (buf_wr_en) b_wr <= b_wr + 1;
            if (buf_frm_init) begin
                b_rd <= b_frm;
            end else if (buf_rd_jump) begin
                b_frm <= b_frm + HOP;
                b_rd  <= b_frm + HOP;
            end else if (buf_rd_en) begin
                b_rd <= b_rd + 1;
            end
        end
    end
    assign buf_full  = (b_wr - b_frm) >= BUF_DEPTH;
    assign buf_empty = force_empty || (b_rd >= b_wr);

    // Reference model: frame k reads samples k*HOP .. k*HOP+WIN-1, one per
    // non-empty cycle after the init cycle, outputs trail reads by one cycle.
    int   rd_in_frame;
    int   frames_read;
    int   frames_out;
    int   avail_m;
    int   jumps;
    int   inits;
    int   ovs;
    int   dones;
    logic in_read;
    logic init_prev;
    logic exp_ov;
    logic exp_first;
    logic exp_last;

    initial begin
        logic exp_rd;
        logic jump_m;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rd_in_frame = 0;
                frames_read = 0;
                frames_out  = 0;
                avail_m     = 0;
                in_read     = 1'b0;
                init_prev   = 1'b0;
                exp_ov      = 1'b0;
                exp_first   = 1'b0;
                exp_last    = 1'b0;
            end else begin
                if (init_prev) in_read = 1'b1;
                tests_run++;
                if ({out_valid, out_first, out_last} !== {exp_ov, exp_first, exp_last}) begin
                    tests_failed++;
                    $display("FAIL out_flags t=%0t got v/f/l=%b%b%b want %b%b%b",
                             $time, out_valid, out_first, out_last, exp_ov, exp_first, exp_last);
                end
                if (out_last) frames_out++;
                if (out_valid) begin
                    tests_run++;
                    if (frame_idx !== 16'(frames_out)) begin
                        tests_failed++;
                        $display("FAIL frame_idx t=%0t got %0d want %0d", $time, frame_idx, frames_out);
                    end
                end
                tests_run++;
                if (dut.avail_q !== 10'(avail_m)) begin
                    tests_failed++;
                    $display("FAIL avail t=%0t got %0d want %0d", $time, dut.avail_q, avail_m);
                end
                tests_run++;
                if (in_ready !== (busy & ~buf_full) || buf_wr_en !== (in_valid & in_ready)) begin
                    tests_failed++;
                    $display("FAIL handshake t=%0t got rdy=%b wr=%b want rdy=%b wr=%b", $time,
                             in_ready, buf_wr_en, busy & ~buf_full, in_valid & busy & ~buf_full);
                end
                exp_rd = in_read && !buf_empty;
                jump_m = exp_rd && (rd_in_frame == WIN - 1);
                tests_run++;
                if (buf_rd_en !== exp_rd || buf_rd_jump !== jump_m) begin
                    tests_failed++;
                    $display("FAIL rd_ctrl t=%0t got rd=%b jump=%b want rd=%b jump=%b",
                             $time, buf_rd_en, buf_rd_jump, exp_rd, jump_m);
                end
                if (buf_rd_en) begin
                    tests_run++;
                    if (b_rd != frames_read * HOP + rd_in_frame) begin
                        tests_failed++;
                        $display("FAIL rd_sample t=%0t got %0d want %0d", $time, b_rd,
                                 frames_read * HOP + rd_in_frame);
                    end
                end
                if (buf_frm_init) begin
                    tests_run++;
                    if (in_read || avail_m < WIN) begin
                        tests_failed++;
                        $display("FAIL frm_init t=%0t got in_read=%b avail=%0d want 0 and >=%0d",
                                 $time, in_read, avail_m, WIN);
                    end
                end
                exp_ov    = exp_rd;
                exp_first = exp_rd && (rd_in_frame == 0);
                exp_last  = jump_m;
                if (exp_rd) rd_in_frame++;
                avail_m = avail_m + (buf_wr_en ? 1 : 0) - (jump_m ? HOP : 0);
                if (jump_m) begin
                    rd_in_frame = 0;
                    frames_read++;
                    in_read = 1'b0;
                end
                init_prev = buf_frm_init;
                if (start && !busy) frames_out = 0;
                jumps += buf_rd_jump ? 1 : 0;
                inits += buf_frm_init ? 1 : 0;
                ovs   += out_valid ? 1 : 0;
                dones += done ? 1 : 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        in_valid    = 1'b0;
        force_empty = 1'b0;
        n_frames    = 16'd0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_start(input logic [15:0] n);
        start    = 1'b1;
        n_frames = n;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input int valid_pct, input int empty_pct,
                                  input int glitch_at, output bit timed_out,
                                  output logic [15:0] fidx, output logic busy_at);
        timed_out = 1'b1;
        fidx      = 16'hFFFF;
        busy_at   = 1'b1;
        for (int c = 0; c < budget; c++) begin
            in_valid    = (int'($urandom_range(99)) < valid_pct);
            force_empty = (int'($urandom_range(99)) < empty_pct);
            if (c == glitch_at) begin
                start    = 1'b1;
                n_frames = 16'($urandom_range(9, 1));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                timed_out = 1'b0;
                fidx      = frame_idx;
                busy_at   = busy;
                break;
            end
            tick();
        end
        start       = 1'b0;
        in_valid    = 1'b0;
        force_empty = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b1;
        stop     = 1'b1;
        in_valid = 1'b1;
        n_frames = 16'd5;
        force_empty = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({in_ready, buf_wr_en, buf_rd_en, buf_rd_jump, buf_frm_init, out_valid,
             out_first, out_last, busy, done, frame_idx} !== 26'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs got rdy=%b wr=%b rd=%b busy=%b done=%b fidx=%0d want all 0",
                     in_ready, buf_wr_en, buf_rd_en, busy, done, frame_idx);
        end
        tests_run++;
        if (dut.avail_q !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_avail got %0d want 0", dut.avail_q);
        end
        do_reset();
    endtask

    task automatic test_three_frames();
        int wr;
        int o0, j0, i0, d0;
        bit to;
        logic [15:0] fidx;
        logic bz;
        do_reset();
        o0 = ovs; j0 = jumps; i0 = inits; d0 = dones;
        wr = 0;
        in_valid = 1'b1;
        pulse_start(16'd3);
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (buf_frm_init) break;
            if (buf_wr_en) wr++;
            tick();
        end
        tests_run++;
        if (wr < WIN || wr > WIN + 1) begin
            tests_failed++;
            $display("FAIL first_init_writes got %0d want %0d..%0d", wr, WIN, WIN + 1);
        end
        tick();
        run_until_done(10000, 100, 0, -1, to, fidx, bz);
        tests_run++;
        if (to || fidx !== 16'd3 || bz !== 1'b0) begin
            tests_failed++;
            $display("FAIL three_done got to=%0d fidx=%0d busy=%b want 0/3/0", to, fidx, bz);
        end
        tests_run++;
        if (ovs - o0 != 3 * WIN || jumps - j0 != 3 || inits - i0 != 3 || dones - d0 != 1) begin
            tests_failed++;
            $display("FAIL three_counts got ov=%0d jump=%0d init=%0d done=%0d want %0d/3/3/1",
                     ovs - o0, jumps - j0, inits - i0, dones - d0, 3 * WIN);
        end
    endtask

    task automatic test_fill_gap();
        int rd_gap, init_gap, o0;
        bit to;
        logic [15:0] fidx;
        logic bz;
        do_reset();
        o0 = ovs;
        in_valid = 1'b1;
        pulse_start(16'd3);
        for (int c = 0; c < 5000 && frames_read < 2; c++) tick();
        rd_gap = 0;
        init_gap = 0;
        in_valid = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            rd_gap   += buf_rd_en ? 1 : 0;
            init_gap += buf_frm_init ? 1 : 0;
            tick();
        end
        tests_run++;
        if (rd_gap != 0 || init_gap != 0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL fill_gap got rd=%0d init=%0d busy=%b want 0/0/1", rd_gap, init_gap, busy);
        end
        run_until_done(10000, 100, 0, -1, to, fidx, bz);
        tests_run++;
        if (to || fidx !== 16'd3 || ovs - o0 != 3 * WIN) begin
            tests_failed++;
            $display("FAIL fill_gap_done got to=%0d fidx=%0d ov=%0d want 0/3/%0d", to, fidx, ovs - o0, 3 * WIN);
        end
    endtask

    task automatic test_stall();
        int rd_stall, j0, o0;
        bit to;
        logic [15:0] fidx;
        logic bz;
        do_reset();
        j0 = jumps; o0 = ovs;
        in_valid = 1'b1;
        pulse_start(16'd1);
        for (int c = 0; c < 3000 && rd_in_frame != 240; c++) tick();
        rd_stall = 0;
        force_empty = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            rd_stall += buf_rd_en ? 1 : 0;
            tick();
        end
        force_empty = 1'b0;
        tests_run++;
        if (rd_stall != 0 || rd_in_frame != 240) begin
            tests_failed++;
            $display("FAIL stall_reads got rd=%0d pos=%0d want 0/240", rd_stall, rd_in_frame);
        end
        run_until_done(3000, 100, 0, -1, to, fidx, bz);
        tests_run++;
        if (to || fidx !== 16'd1 || jumps - j0 != 1 || ovs - o0 != WIN) begin
            tests_failed++;
            $display("FAIL stall_done got to=%0d fidx=%0d jump=%0d ov=%0d want 0/1/1/%0d",
                     to, fidx, jumps - j0, ovs - o0, WIN);
        end
    endtask

    task automatic test_jump_write();
        int wr;
        bit seen;
        do_reset();
        wr = 0;
        seen = 1'b0;
        pulse_start(16'd1);
        for (int c = 0; c < 3000 && !seen; c++) begin
            in_valid = (wr < WIN) || buf_rd_jump;
            @(negedge clk);
            if (buf_wr_en) wr++;
            if (buf_rd_jump) begin
                seen = 1'b1;
                tests_run++;
                if (dut.avail_q !== 10'(WIN) || buf_wr_en !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL jump_pre got avail=%0d wr=%b want %0d/1", dut.avail_q, buf_wr_en, WIN);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (!seen || dut.avail_q !== 10'(WIN + 1 - HOP) || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL jump_write got seen=%0d avail=%0d done=%b want 1/%0d/1",
                     seen, dut.avail_q, done, WIN + 1 - HOP);
        end
        tick();
    endtask

    task automatic test_stop_read();
        int j0, o0, d0;
        bit to;
        logic [15:0] fidx;
        logic bz;
        do_reset();
        j0 = jumps; o0 = ovs; d0 = dones;
        in_valid = 1'b1;
        pulse_start(16'd0);
        for (int c = 0; c < 3000 && rd_in_frame != 100; c++) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        run_until_done(3000, 100, 0, -1, to, fidx, bz);
        tests_run++;
        if (to || fidx !== 16'd1 || bz !== 1'b0) begin
            tests_failed++;
            $display("FAIL stop_read got to=%0d fidx=%0d busy=%b want 0/1/0", to, fidx, bz);
        end
        tests_run++;
        if (jumps - j0 != 1 || ovs - o0 != WIN || dones - d0 != 1) begin
            tests_failed++;
            $display("FAIL stop_read_counts got jump=%0d ov=%0d done=%0d want 1/%0d/1",
                     jumps - j0, ovs - o0, dones - d0, WIN);
        end
    endtask

    task automatic test_stop_fill();
        int i0;
        do_reset();
        i0 = inits;
        in_valid = 1'b1;
        pulse_start(16'd0);
        repeat (10) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        @(negedge clk);
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || inits != i0) begin
            tests_failed++;
            $display("FAIL stop_fill got done=%b busy=%b inits=%0d want 1/0/0", done, busy, inits - i0);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int o0;
        bit to;
        logic [15:0] fidx;
        logic bz;
        do_reset();
        in_valid = 1'b1;
        pulse_start(16'd1);
        for (int c = 0; c < 3000 && rd_in_frame != 200; c++) tick();
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({in_ready, buf_wr_en, buf_rd_en, buf_rd_jump, buf_frm_init, out_valid,
             out_first, out_last, busy, done, frame_idx} !== 26'd0) begin
            tests_failed++;
            $display("FAIL midframe_reset got rd=%b ov=%b busy=%b fidx=%0d want all 0",
                     buf_rd_en, out_valid, busy, frame_idx);
        end
        tick();
        rst_n = 1'b1;
        tick();
        o0 = ovs;
        pulse_start(16'd1);
        run_until_done(3000, 100, 0, -1, to, fidx, bz);
        tests_run++;
        if (to || fidx !== 16'd1 || ovs - o0 != WIN) begin
            tests_failed++;
            $display("FAIL restart got to=%0d fidx=%0d ov=%0d want 0/1/%0d", to, fidx, ovs - o0, WIN);
        end
    endtask

    task automatic test_random();
        int n, o0, d0;
        bit to;
        logic [15:0] fidx;
        logic bz;
        do_reset();
        for (int it = 0; it < 3; it++) begin
            n  = int'($urandom_range(3, 1));
            o0 = ovs;
            d0 = dones;
            pulse_start(16'(n));
            run_until_done(20000, int'($urandom_range(100, 50)), int'($urandom_range(20)),
                           300, to, fidx, bz);
            tests_run++;
            if (to || fidx !== 16'(n) || ovs - o0 != n * WIN || dones - d0 != 1) begin
                tests_failed++;
                $display("FAIL random_%0d got to=%0d fidx=%0d ov=%0d done=%0d want 0/%0d/%0d/1",
                         it, to, fidx, ovs - o0, dones - d0, n, n * WIN);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        jumps = 0; inits = 0; ovs = 0; dones = 0;
        test_reset();
        test_three_frames();
        test_fill_gap();
        test_stall();
        test_jump_write();
        test_stop_read();
        test_stop_fill();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
